kernel_fifo_sink: RTL and testbench

- Consumer end of the HLS ap_fifo output protocol (din / full_n / write) driven by a kernel output stream such as q_out or s_out.
- Replaces the tied-high full_n with a real bounded FIFO, controlled drain rate and optional backpressure. This exercises kernel stall paths during power characterisation.
- Each drained word is XOR-folded to 4 bits for the board-level data_out/data_valid pins.
- Counts accepted words per run and checks the count against the expected stream length.

---
 rtl/kernel_fifo_sink.sv | 200 ++++++++++++++++++++
 tb/tb_kernel_fifo_sink.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_fifo_sink.sv
// kernel_fifo_sink
//
// Consumer end of an HLS ap_fifo output stream (din / full_n / write). It
// buffers kernel words in a bounded FIFO, drains them at a fixed maximum rate
// and XOR-folds each drained word down to one nibble for board-level pins. It
// also counts the words accepted per run and flags a count that differs from
// EXPECTED_WORDS when the run finishes.
//
// Optional feature: define KERNEL_FIFO_SINK_BACKPRESSURE_EN to add periodic
// backpressure. fifo_full_n is then forced low one cycle in every BP_PERIOD
// while a run is active.
//
// Ports:
//   ap_clk       clock, all logic on the rising edge
//   ap_rst       synchronous active-high reset
//   ap_start     kernel start; opens a run when idle
//   ap_done      kernel done pulse; ends the accept phase of a run
//   fifo_din     kernel stream data
//   fifo_write   kernel write strobe
//   fifo_full_n  not-full back to the kernel
//   data_out     XOR-folded drained word (holds while data_valid is low)
//   data_valid   data_out qualifier
//   word_count   words accepted in the current or last run (saturating)
//   count_err    word_count != EXPECTED_WORDS at the end of the last run
//   ovf_err      sticky: a write arrived while fifo_full_n was low
//   run_done     one-cycle pulse once a run is drained and checked

module kernel_fifo_sink #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int DRAIN_INV      = 1,
  parameter int EXPECTED_WORDS = 64,
  parameter int BP_PERIOD      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] fifo_din,
  input  logic                  fifo_write,
  output logic                  fifo_full_n,
  output logic [3:0]            data_out,
  output logic                  data_valid,
  output logic [15:0]           word_count,
  output logic                  count_err,
  output logic                  ovf_err,
  output logic                  run_done
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int DCW     = (DRAIN_INV > 1) ? $clog2(DRAIN_INV) : 1;
  localparam int NIBBLES = DATA_WIDTH / 4;

  localparam logic [AW:0]    DEPTH_L    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_INV - 1);
  localparam logic [15:0]    EXPECT_L   = 16'(EXPECTED_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Elaboration-time guard against parameter values the logic cannot support.
  if (((DATA_WIDTH % 4) != 0) || (DATA_WIDTH < 4) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (DRAIN_INV < 1) ||
      (BP_PERIOD < 2) || (EXPECTED_WORDS < 0) || (EXPECTED_WORDS > 65535)) begin : g_bad_params
    $error("kernel_fifo_sink: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           occ_q, occ_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic                  rd_valid_q;
  logic [3:0]            data_out_q, fold_d;
  logic                  data_valid_q;
  logic [15:0]           word_count_q, word_count_d;
  logic                  count_err_q, count_err_d;
  logic                  ovf_err_q, ovf_err_d;
  logic                  bp_block;
  logic                  push, pop;

`ifdef KERNEL_FIFO_SINK_BACKPRESSURE_EN
  localparam int            BW      = $clog2(BP_PERIOD);
  localparam logic [BW-1:0] BP_LAST = BW'(BP_PERIOD - 1);

  logic [BW-1:0] bp_cnt_q, bp_cnt_d;

  assign bp_cnt_d = (bp_cnt_q == BP_LAST) ? '0 : bp_cnt_q + BW'(1);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) bp_cnt_q <= '0;
    else        bp_cnt_q <= bp_cnt_d;
  end

  // The stall slot only bites while a run is open; idle and DONE ignore it.
  assign bp_block = (bp_cnt_q == BP_LAST) && ((state_q == S_RUN) || (state_q == S_DRAIN));
`else
  assign bp_block = 1'b0;
`endif

  // full_n is based on occupancy before any same-cycle pop, so a full FIFO
  // that is popping this cycle still refuses the incoming write.
  assign fifo_full_n = (occ_q != DEPTH_L) && (state_q != S_DONE) && !bp_block;
  assign push        = fifo_write && fifo_full_n;
  assign pop         = (drain_cnt_q == '0) && (occ_q != '0);

  assign drain_cnt_d = (drain_cnt_q == DRAIN_LAST) ? '0 : drain_cnt_q + DCW'(1);
  assign wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign ovf_err_d   = ovf_err_q || (fifo_write && !fifo_full_n);

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + (AW + 1)'(1);
    else if (!push && pop) occ_d = occ_q - (AW + 1)'(1);
  end

  always_comb begin
    fold_d = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      fold_d = fold_d ^ rd_word_q[i*4 +: 4];
    end
  end

  // Run control. DRAIN also waits for the read stage to empty so that
  // run_done lands strictly after the last data_valid of the run.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    count_err_d  = count_err_q;
    if (push && (word_count_q != 16'hFFFF)) word_count_d = word_count_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d      = S_RUN;
          word_count_d = push ? 16'd1 : 16'd0;
          count_err_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (ap_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((occ_q == '0) && !push && !rd_valid_q) state_d = S_DONE;
      end
      S_DONE: begin
        count_err_d = (word_count_q != EXPECT_L);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage array carries no reset; occupancy and pointers define its contents.
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_din;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      drain_cnt_q  <= '0;
      state_q      <= S_IDLE;
      rd_word_q    <= '0;
      rd_valid_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      word_count_q <= '0;
      count_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      drain_cnt_q  <= drain_cnt_d;
      state_q      <= state_d;
      rd_valid_q   <= pop;
      if (pop) rd_word_q <= mem_q[rd_ptr_q];
      data_valid_q <= rd_valid_q;
      if (rd_valid_q) data_out_q <= fold_d;
      word_count_q <= word_count_d;
      count_err_q  <= count_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign word_count = word_count_q;
  assign count_err  = count_err_q;
  assign ovf_err    = ovf_err_q;
  assign run_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_kernel_fifo_sink.sv
// Testbench for kernel_fifo_sink.
// Two instances share one clock:
//   dutA uses the default buffering (depth 16, drain every cycle).
//   dutB uses a small, slow FIFO (depth 4, drain every 8 cycles), so that
//   overflow and mid-run reset can be exercised.
// Expected drained nibbles are queued when a write is issued. A monitor per
// instance pops the queue on every data_valid and compares the result.
module tb_kernel_fifo_sink;

   typedef struct {
      logic [3:0] nib;
      int         due;
   } expT;

   logic        ap_clk = 1'b0;

   logic        aRst, aStart, aDone, aWrite;
   logic [31:0] aDin;
   logic        aFullN, aValid, aCountErr, aOvf, aRunDone;
   logic [3:0]  aDataOut;
   logic [15:0] aWordCount;

   logic        bRst, bStart, bDone, bWrite;
   logic [31:0] bDin;
   logic        bFullN, bValid, bCountErr, bOvf, bRunDone;
   logic [3:0]  bDataOut;
   logic [15:0] bWordCount;

   int  compared   = 0;
   int  mismatched = 0;
   int  cyc        = 0;
   int  aLastValid = -1;
   int  bLastValid = -1;
   expT aQ[$];
   expT bQ[$];

   logic [31:0] ovfWords  [9] = '{32'h00000001, 32'h00000020, 32'h00000300, 32'h00004000,
                                  32'h06000000, 32'h70000000, 32'h00000009, 32'h0000000E,
                                  32'h00500000};
   logic [3:0]  ovfNib    [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h9, 4'hE, 4'h5};
   bit          ovfAccept [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   bit          ovfFullN  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   bit          ovfFlag   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   kernel_fifo_sink #(
      .DATA_WIDTH(32), .FIFO_DEPTH(16), .DRAIN_INV(1), .EXPECTED_WORDS(64), .BP_PERIOD(4)
   ) dutA (
      .ap_clk(ap_clk), .ap_rst(aRst), .ap_start(aStart), .ap_done(aDone),
      .fifo_din(aDin), .fifo_write(aWrite), .fifo_full_n(aFullN),
      .data_out(aDataOut), .data_valid(aValid), .word_count(aWordCount),
      .count_err(aCountErr), .ovf_err(aOvf), .run_done(aRunDone)
   );

   kernel_fifo_sink #(
      .DATA_WIDTH(32), .FIFO_DEPTH(4), .DRAIN_INV(8), .EXPECTED_WORDS(64), .BP_PERIOD(8)
   ) dutB (
      .ap_clk(ap_clk), .ap_rst(bRst), .ap_start(bStart), .ap_done(bDone),
      .fifo_din(bDin), .fifo_write(bWrite), .fifo_full_n(bFullN),
      .data_out(bDataOut), .data_valid(bValid), .word_count(bWordCount),
      .count_err(bCountErr), .ovf_err(bOvf), .run_done(bRunDone)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) cyc <= cyc + 1;

   // Reference fold: bit j of the result is the parity of every fourth bit starting at j.
   function automatic logic [3:0] foldRef(input logic [31:0] d);
      logic [3:0] r;
      for (int j = 0; j < 4; j++) r[j] = ^(d & (32'h11111111 << j));
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic reportUnexpected(input string name, input logic [3:0] value);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: data_valid with data_out=%0h, expected no output (cycle %0d)", name, value, cyc);
   endtask

   // Scoreboard monitors: one pop per data_valid, compared in issue order.
   always @(negedge ap_clk) begin
      if (aValid) begin
         if (aQ.size() == 0) reportUnexpected("aUnexpectedValid", aDataOut);
         else begin
            checkOutput("aDataOut", 32'(aDataOut), 32'(aQ[0].nib));
            if (aQ[0].due >= 0) checkOutput("aLatency", 32'(cyc), 32'(aQ[0].due));
            aQ.delete(0);
         end
         aLastValid <= cyc;
      end
   end

   always @(negedge ap_clk) begin
      if (bValid) begin
         if (bQ.size() == 0) reportUnexpected("bUnexpectedValid", bDataOut);
         else begin
            checkOutput("bDataOut", 32'(bDataOut), 32'(bQ[0].nib));
            bQ.delete(0);
         end
         bLastValid <= cyc;
      end
   end

   // One kernel write into dutA, issued only once fifo_full_n is high.
   // The drained nibble is due three cycles after the accepted write.
   task automatic applyStimulus(input logic [31:0] d, input logic [3:0] expNib, input bit withDone);
      int waitCnt = 0;
      while (!aFullN && waitCnt < 20) begin
         @(negedge ap_clk);
         waitCnt++;
      end
      if (!aFullN) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL aWriteStall: fifo_full_n=0, expected 1 within 20 cycles");
      end else begin
         aWrite = 1'b1;
         aDin   = d;
         aDone  = withDone;
         aQ.push_back('{expNib, cyc + 3});
         @(negedge ap_clk);
         aWrite = 1'b0;
         aDone  = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge ap_clk);
   endtask

   task automatic startRun(input bit sel);
      if (sel) bStart = 1'b1; else aStart = 1'b1;
      @(negedge ap_clk);
      bStart = 1'b0;
      aStart = 1'b0;
   endtask

   task automatic pulseDone(input bit sel);
      if (sel) bDone = 1'b1; else aDone = 1'b1;
      @(negedge ap_clk);
      bDone = 1'b0;
      aDone = 1'b0;
   endtask

   task automatic resetB();
      bRst = 1'b1;
      @(negedge ap_clk);
      @(negedge ap_clk);
      bRst = 1'b0;
   endtask

   task automatic waitRunDone(input bit sel, input int budget);
      int n = 0;
      string p;
      p = sel ? "b" : "a";
      while (!(sel ? bRunDone : aRunDone) && n < budget) begin
         @(negedge ap_clk);
         n++;
      end
      #1;
      if (!(sel ? bRunDone : aRunDone)) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %sRunDoneTimeout: run_done=0, expected 1 within %0d cycles", p, budget);
      end else begin
         checkOutput({p, "RunDoneAfterLastValid"}, 32'(cyc > (sel ? bLastValid : aLastValid)), 32'd1);
         checkOutput({p, "AllWordsDelivered"}, 32'(sel ? bQ.size() : aQ.size()), 32'd0);
         checkOutput({p, "FullNInDone"}, 32'(sel ? bFullN : aFullN), 32'd0);
         @(negedge ap_clk);
         checkOutput({p, "RunDonePulseWidth"}, 32'(sel ? bRunDone : aRunDone), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] w;
      int          runDoneSeen;
      aRst = 1'b1; aStart = 1'b0; aDone = 1'b0; aWrite = 1'b0; aDin = '0;
      bRst = 1'b1; bStart = 1'b0; bDone = 1'b0; bWrite = 1'b0; bDin = '0;
      idle(3);
      aRst = 1'b0;
      bRst = 1'b0;

      // Reset state
      checkOutput("aResetFullN",     32'(aFullN),     32'd1);
      checkOutput("aResetValid",     32'(aValid),     32'd0);
      checkOutput("aResetDataOut",   32'(aDataOut),   32'd0);
      checkOutput("aResetWordCount", 32'(aWordCount), 32'd0);
      checkOutput("aResetCountErr",  32'(aCountErr),  32'd0);
      checkOutput("aResetOvf",       32'(aOvf),       32'd0);
      checkOutput("aResetRunDone",   32'(aRunDone),   32'd0);
      checkOutput("bResetFullN",     32'(bFullN),     32'd1);

      // Fold check with isolated writes
      $display("[TB] fold check");
      startRun(1'b0);
      applyStimulus(32'h12345678, 4'h8, 1'b0); idle(4);
      applyStimulus(32'hFFFFFFFF, 4'h0, 1'b0); idle(4);
      applyStimulus(32'h0000000A, 4'hA, 1'b0); idle(4);
      pulseDone(1'b0);
      waitRunDone(1'b0, 20);
      checkOutput("aFoldWordCount", 32'(aWordCount), 32'd3);
      checkOutput("aFoldCountErr",  32'(aCountErr),  32'd1);
      checkOutput("aDataOutHold",   32'(aDataOut),   32'hA);

      // Exactly EXPECTED_WORDS back to back
      $display("[TB] count check, 64 words");
      startRun(1'b0);
      for (int i = 0; i < 64; i++) begin
         w = 32'h9E3779B9 * 32'(i + 1);
         applyStimulus(w, foldRef(w), 1'b0);
      end
      pulseDone(1'b0);
      waitRunDone(1'b0, 30);
      checkOutput("a64WordCount", 32'(aWordCount), 32'd64);
      checkOutput("a64CountErr",  32'(aCountErr),  32'd0);

      // 63 words, the last one alongside ap_done
      $display("[TB] count check, 63 words");
      startRun(1'b0);
      for (int i = 0; i < 63; i++) begin
         w = 32'hC001D00D ^ (32'h01010101 * 32'(i));
         applyStimulus(w, foldRef(w), i == 62);
      end
      waitRunDone(1'b0, 30);
      checkOutput("a63WordCount", 32'(aWordCount), 32'd63);
      checkOutput("a63CountErr",  32'(aCountErr),  32'd1);
      checkOutput("aOvfStillClear", 32'(aOvf), 32'd0);

`ifdef KERNEL_FIFO_SINK_BACKPRESSURE_EN
      // Periodic backpressure with a kernel that honours fifo_full_n
      begin
         int lowCount   = 0;
         int lastLow    = -1;
         int spacingBad = 0;
         $display("[TB] backpressure check");
         startRun(1'b0);
         for (int i = 0; i < 24; i++) begin
            if (!aFullN) begin
               if (lastLow >= 0 && (i - lastLow) != 4) spacingBad++;
               lastLow = i;
               lowCount++;
               aWrite = 1'b0;
            end else begin
               w = 32'h0F1E2D3C + 32'(i);
               aWrite = 1'b1;
               aDin   = w;
               aQ.push_back('{foldRef(w), cyc + 3});
            end
            @(negedge ap_clk);
         end
         aWrite = 1'b0;
         checkOutput("bpLowCount", 32'(lowCount),   32'd6);
         checkOutput("bpSpacing",  32'(spacingBad), 32'd0);
         checkOutput("bpOvf",      32'(aOvf),       32'd0);
         pulseDone(1'b0);
         waitRunDone(1'b0, 30);
      end
`else
      // Overflow on the small FIFO with the write held high
      $display("[TB] overflow check");
      resetB();
      startRun(1'b1);
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("bFullN[%0d]", i), 32'(bFullN), 32'(ovfFullN[i]));
         checkOutput($sformatf("bOvf[%0d]", i),   32'(bOvf),   32'(ovfFlag[i]));
         bWrite = 1'b1;
         bDin   = ovfWords[i];
         if (ovfAccept[i]) bQ.push_back('{ovfNib[i], -1});
         @(negedge ap_clk);
      end
      bWrite = 1'b0;
      checkOutput("bOvfWordCount", 32'(bWordCount), 32'd5);
      pulseDone(1'b1);
      waitRunDone(1'b1, 100);
      checkOutput("bOvfCountErr", 32'(bCountErr), 32'd1);
      checkOutput("bOvfSticky",   32'(bOvf),      32'd1);
`endif

      // Reset mid-run with three words buffered
      $display("[TB] mid-run reset check");
      resetB();
      checkOutput("bOvfClearedByReset", 32'(bOvf), 32'd0);
      startRun(1'b1);
      for (int i = 0; i < 3; i++) begin
         bWrite = 1'b1;
         bDin   = 32'hBAD00000 + 32'(i);
         @(negedge ap_clk);
      end
      bWrite = 1'b0;
      checkOutput("bBufferedWordCount", 32'(bWordCount), 32'd3);
      bRst = 1'b1;
      @(negedge ap_clk);
      bRst = 1'b0;
      checkOutput("bMidResetWordCount", 32'(bWordCount), 32'd0);
      checkOutput("bMidResetFullN",     32'(bFullN),     32'd1);
      runDoneSeen = 0;
      for (int i = 0; i < 30; i++) begin
         if (bRunDone) runDoneSeen++;
         @(negedge ap_clk);
      end
      checkOutput("bNoRunDoneAfterReset", 32'(runDoneSeen), 32'd0);
      checkOutput("bWordCountAfterIdle",  32'(bWordCount),  32'd0);

      idle(5);
      checkOutput("aQueueEmptyAtEnd", 32'(aQ.size()), 32'd0);
      checkOutput("bQueueEmptyAtEnd", 32'(bQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
